uart_tx_arbiter: RTL and testbench

//  Shares the single UARTTransmitter between NUM_REQ byte-stream producers (board display, init banner,

---
 rtl/uart_tx_arbiter_pkg.sv | 36 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter_pkg
// Description : State encodings, ASCII constants and width helpers shared by
//               the UART transmit arbiter and the display/command logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

    localparam logic [1:0] c_ARB_IDLE  = 2'd0;
    localparam logic [1:0] c_ARB_LOAD  = 2'd1;
    localparam logic [1:0] c_ARB_START = 2'd2;
    localparam logic [1:0] c_ARB_DRAIN = 2'd3;

    localparam logic [7:0] c_ASCII_ESC      = 8'd27;
    localparam logic [7:0] c_ASCII_LBRACKET = 8'd91;
    localparam logic [7:0] c_ASCII_SEMI     = 8'd59;
    localparam logic [7:0] c_ASCII_H        = 8'd72;
    localparam logic [7:0] c_ASCII_CR       = 8'd13;
    localparam logic [7:0] c_ASCII_LF       = 8'd10;
    localparam logic [7:0] c_ASCII_O        = 8'd79;
    localparam logic [7:0] c_ASCII_SPACE    = 8'd32;

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // A zero timeout still needs a 1-bit timer so the port widths stay legal.
    function automatic int timer_width(input int lock_timeout);
        return (lock_timeout > 0) ? $clog2(lock_timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter_rr_pick
// Description : Combinational round-robin picker: lowest requesting index at or
//               after the pointer wins, wrapping to index 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [PTR_W-1:0]   o_winner_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pool;

    always_comb begin
        w_hi = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_hi[j] = i_req[j] && (PTR_W'(j) >= i_ptr);
        end
    end

    // Requesters at/after the pointer take priority; otherwise wrap around.
    always_comb begin
        w_pool       = (|w_hi) ? w_hi : i_req;
        o_winner     = '0;
        o_winner_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_pool[j]) begin
                o_winner     = '0;
                o_winner[j]  = 1'b1;
                o_winner_idx = PTR_W'(j);
            end
        end
    end

    assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing one UART
//               transmitter between NUM_REQ byte-stream producers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 240000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 timeout_err
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int TMR_W = timer_width(LOCK_TIMEOUT);

    localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] c_TMO_LAST = (LOCK_TIMEOUT > 0) ? TMR_W'(LOCK_TIMEOUT - 1) : '0;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   r_ptr;
    logic [TMR_W-1:0]   r_timer;
    logic               r_last;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic [NUM_REQ-1:0] r_req_ready;
    logic               r_timeout_err;

    logic [NUM_REQ-1:0] w_winner;
    logic [PTR_W-1:0]   w_winner_idx;
    logic               w_any;
    logic [7:0]         w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [PTR_W-1:0]   w_ptr_next;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_ptr        (r_ptr),
        .o_winner     (w_winner),
        .o_winner_idx (w_winner_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant[j]) w_sel_data = req_data[8*j +: 8];
        end
    end

    assign w_sel_valid = |(req_valid & r_grant);
    assign w_sel_last  = |(req_last & r_grant);
    assign w_ptr_next  = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ARB_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_ptr         <= '0;
            r_timer       <= '0;
            r_last        <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_gidx  <= w_winner_idx;
                        r_timer <= '0;
                        r_state <= c_ARB_LOAD;
                    end
                end
                c_ARB_LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data   <= w_sel_data;
                        r_last      <= w_sel_last;
                        r_req_ready <= r_grant;
                        r_timer     <= '0;
                        r_state     <= c_ARB_START;
                    end else if (LOCK_TIMEOUT != 0 && r_timer == c_TMO_LAST) begin
                        // Producer stalled mid-packet: release so others can run.
                        r_grant       <= '0;
                        r_ptr         <= w_ptr_next;
                        r_timer       <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= c_ARB_IDLE;
                    end else if (LOCK_TIMEOUT != 0) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ARB_START: begin
                    if (tx_ready && !r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_state    <= c_ARB_DRAIN;
                    end
                end
                c_ARB_DRAIN: begin
                    // Transmitter dropping ready means it has taken the byte.
                    if (r_tx_valid && !tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= w_ptr_next;
                            r_state <= c_ARB_IDLE;
                        end else begin
                            r_state <= c_ARB_LOAD;
                        end
                    end
                end
                default: r_state <= c_ARB_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign grant       = r_grant;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with packet producers,
//               a busy-modelling transmitter and a packet-level RR reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NR  = 3;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic            timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .timeout_err (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] pbuf [NR][256];
    int         head [NR];
    int         tail [NR];
    int         gap  [NR];
    int         rdy_cnt [NR];
    int         terr_cnt = 0;
    int         onehot_viol = 0;
    int         busy = 0;
    int         busy_max = 1;
    bit         gaps_on = 1'b0;
    bit         tx_hold = 1'b0;
    int         m_ptr = 0;
    logic [9:0] obs [$];
    logic [9:0] exp_q [$];

    function automatic logic [1:0] gidx(input logic [NR-1:0] g);
        for (int k = 0; k < NR; k++) if (g[k]) return 2'(k);
        return 2'd3;
    endfunction

    // Producers, transmitter model and monitors, all evaluated on the falling edge.
    initial begin : env
        forever begin
            @(negedge clk);
            if (reset) begin
                tx_ready = 1'b1;
                busy     = 0;
            end else begin
                if (grant != '0 && !$onehot(grant)) onehot_viol++;
                if (timeout_err) terr_cnt++;
                for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
                if (tx_hold) begin
                    tx_ready = 1'b0;
                end else if (tx_ready && tx_valid) begin
                    obs.push_back({gidx(grant), tx_data});
                    tx_ready = 1'b0;
                    busy     = $urandom_range(busy_max, 1);
                end else if (!tx_ready) begin
                    if (busy > 0) busy--;
                    if (busy == 0) tx_ready = 1'b1;
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i] && head[i] != tail[i]) begin
                        if (gaps_on && !pbuf[i][8'(head[i])][8] && $urandom_range(2, 0) == 0)
                            gap[i] = $urandom_range(5, 1);
                        head[i]++;
                    end else if (gap[i] > 0) begin
                        gap[i]--;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i]      = (head[i] != tail[i]) && (gap[i] == 0);
                req_data[8*i +: 8] = pbuf[i][8'(head[i])][7:0];
                req_last[i]       = pbuf[i][8'(head[i])][8];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0; tail[i] = 0; gap[i] = 0; rdy_cnt[i] = 0;
            for (int k = 0; k < 256; k++) pbuf[i][k] = '0;
        end
        terr_cnt = 0; onehot_viol = 0;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tx_hold = 1'b0; gaps_on = 1'b0; busy_max = 1;
        tick(); tick();
        clear_env();
        m_ptr = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        pbuf[r][8'(tail[r])] = {l, b};
        tail[r]++;
    endtask

    // Packet-level round robin over everything currently queued.
    task automatic model_build();
        int h [NR];
        int w;
        int c;
        for (int i = 0; i < NR; i++) h[i] = head[i];
        exp_q.delete();
        forever begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (w < 0 && h[c] != tail[c]) w = c;
            end
            if (w < 0) break;
            do begin
                exp_q.push_back({2'(w), pbuf[w][8'(h[w])][7:0]});
                h[w]++;
            end while (!pbuf[w][8'(h[w] - 1)][8] && h[w] != tail[w]);
            m_ptr = (w + 1) % NR;
        end
    endtask

    task automatic wait_done(input int want, input string nm);
        int n;
        bit busy_q;
        n = 0;
        busy_q = 1'b1;
        while (busy_q && n < 3000) begin
            busy_q = (obs.size() < want) || (grant != '0);
            for (int i = 0; i < NR; i++) if (head[i] != tail[i]) busy_q = 1'b1;
            if (busy_q) begin tick(); n++; end
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_drain got=%0d cycles required<3000 (obs=%0d want=%0d)", nm, n, obs.size(), want);
        end
    endtask

    task automatic test_reset();
        tick();
        total += 5;
        if (grant !== '0)       begin bad++; $display("FAIL rst_grant got=%b want=0", grant); end
        if (req_ready !== '0)   begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        if (tx_valid !== 1'b0)  begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
        if (tx_data !== 8'h00)  begin bad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%b want=0", timeout_err); end
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if (grant !== '0) begin bad++; $display("FAIL rst_idle_grant got=%b want=0", grant); end
    endtask

    task automatic test_single_stream();
        logic [7:0] bytes [4];
        bytes[0] = 8'h1B; bytes[1] = 8'h5B; bytes[2] = 8'h3B; bytes[3] = 8'h48;
        apply_reset();
        for (int k = 0; k < 4; k++) push(0, bytes[k], k == 3);
        wait_done(4, "t1");
        total++;
        if (obs.size() != 4) begin bad++; $display("FAIL t1_len got=%0d want=4", obs.size()); end
        for (int k = 0; k < 4 && k < obs.size(); k++) begin
            total++;
            if (obs[k] !== {2'd0, bytes[k]}) begin
                bad++; $display("FAIL t1_byte%0d got=%h want=%h", k, obs[k], {2'd0, bytes[k]});
            end
        end
        total += 2;
        if (rdy_cnt[0] != 4) begin bad++; $display("FAIL t1_ready_pulses got=%0d want=4", rdy_cnt[0]); end
        if (grant !== '0)    begin bad++; $display("FAIL t1_grant_end got=%b want=0", grant); end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
            push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b1);
            model_build();
            wait_done(exp_q.size(), "t2");
            total += 2;
            if (obs.size() != exp_q.size()) begin
                bad++; $display("FAIL t2_len round=%0d got=%0d want=%0d", rnd, obs.size(), exp_q.size());
            end
            if (obs.size() == 0 || obs[0][9:8] !== 2'd0) begin
                bad++; $display("FAIL t2_first_owner round=%0d got=%h want=req0", rnd, (obs.size() > 0) ? obs[0] : 10'h3ff);
            end
            for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
                total++;
                if (obs[k] !== exp_q[k]) begin
                    bad++; $display("FAIL t2_byte%0d round=%0d got=%h want=%h", k, rnd, obs[k], exp_q[k]);
                end
            end
            obs.delete();
        end
    endtask

    task automatic test_mid_packet();
        logic [9:0] want [4];
        int n;
        want[0] = {2'd0, 8'hA1}; want[1] = {2'd0, 8'hA2};
        want[2] = {2'd0, 8'hA3}; want[3] = {2'd1, 8'hB1};
        apply_reset();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        n = 0;
        while (rdy_cnt[0] < 1 && n < 50) begin tick(); n++; end
        push(1, 8'hB1, 1'b1);
        wait_done(4, "t3");
        total++;
        if (obs.size() != 4) begin bad++; $display("FAIL t3_len got=%0d want=4", obs.size()); end
        for (int k = 0; k < 4 && k < obs.size(); k++) begin
            total++;
            if (obs[k] !== want[k]) begin bad++; $display("FAIL t3_byte%0d got=%h want=%h", k, obs[k], want[k]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        int cnt;
        apply_reset();
        push(0, 8'hAA, 1'b0);
        push(1, 8'hBB, 1'b1);
        n = 0;
        while (obs.size() < 1 && n < 50) begin tick(); n++; end
        while (tx_valid !== 1'b0 && n < 60) begin tick(); n++; end
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 100) begin
            if (grant === 3'b001) cnt++;
            tick();
        end
        total += 3;
        if (cnt != TMO)       begin bad++; $display("FAIL t4_load_cycles got=%0d want=%0d", cnt, TMO); end
        if (grant !== 3'b000) begin bad++; $display("FAIL t4_grant_release got=%b want=000", grant); end
        tick();
        if (grant !== 3'b010) begin bad++; $display("FAIL t4_next_grant got=%b want=010", grant); end
        wait_done(2, "t4");
        total += 3;
        if (terr_cnt != 1) begin bad++; $display("FAIL t4_err_pulses got=%0d want=1", terr_cnt); end
        if (obs.size() < 1 || obs[0] !== {2'd0, 8'hAA}) begin bad++; $display("FAIL t4_byte0 got=%h want=%h", (obs.size() > 0) ? obs[0] : 10'h3ff, {2'd0, 8'hAA}); end
        if (obs.size() < 2 || obs[1] !== {2'd1, 8'hBB}) begin bad++; $display("FAIL t4_byte1 got=%h want=%h", (obs.size() > 1) ? obs[1] : 10'h3ff, {2'd1, 8'hBB}); end
    endtask

    task automatic test_reset_in_flight();
        int n;
        apply_reset();
        push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (tx_valid !== 1'b1 && n < 50);
        reset = 1'b1;
        #1;
        total += 3;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL t5_async_tx_valid got=%b want=0", tx_valid); end
        if (grant !== '0)      begin bad++; $display("FAIL t5_async_grant got=%b want=0", grant); end
        if (req_ready !== '0)  begin bad++; $display("FAIL t5_async_req_ready got=%b want=0", req_ready); end
        tick(); tick();
        clear_env();
        m_ptr = 0;
        reset = 1'b0;
        push(0, 8'hD1, 1'b1);
        push(1, 8'hE1, 1'b1);
        model_build();
        wait_done(exp_q.size(), "t5");
        total++;
        if (obs.size() != 2 || obs[0] !== {2'd0, 8'hD1}) begin
            bad++; $display("FAIL t5_winner got=%h want=%h", (obs.size() > 0) ? obs[0] : 10'h3ff, {2'd0, 8'hD1});
        end
        for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
            total++;
            if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL t5_byte%0d got=%h want=%h", k, obs[k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int vhi;
        apply_reset();
        push(0, 8'hF1, 1'b0); push(0, 8'hF2, 1'b1);
        n = 0;
        while (rdy_cnt[0] < 1 && n < 50) begin tick(); n++; end
        tx_hold  = 1'b1;
        tx_ready = 1'b0;
        vhi = 0;
        repeat (100) begin tick(); if (tx_valid) vhi++; end
        total += 3;
        if (vhi != 0)         begin bad++; $display("FAIL t6_valid_held got=%0d want=0", vhi); end
        if (rdy_cnt[0] != 1)  begin bad++; $display("FAIL t6_ready_pulses got=%0d want=1", rdy_cnt[0]); end
        if (terr_cnt != 0)    begin bad++; $display("FAIL t6_timeout got=%0d want=0", terr_cnt); end
        tx_hold = 1'b0;
        wait_done(2, "t6");
        total += 2;
        if (obs.size() < 1 || obs[0] !== {2'd0, 8'hF1}) begin bad++; $display("FAIL t6_byte0 got=%h want=%h", (obs.size() > 0) ? obs[0] : 10'h3ff, {2'd0, 8'hF1}); end
        if (obs.size() < 2 || obs[1] !== {2'd0, 8'hF2}) begin bad++; $display("FAIL t6_byte1 got=%h want=%h", (obs.size() > 1) ? obs[1] : 10'h3ff, {2'd0, 8'hF2}); end
    endtask

    task automatic test_random();
        int nb [NR];
        int npk;
        int len;
        apply_reset();
        for (int rnd = 0; rnd < 8; rnd++) begin
            gaps_on  = 1'b1;
            busy_max = $urandom_range(4, 1);
            for (int r = 0; r < NR; r++) begin
                nb[r] = 0;
                npk = $urandom_range(3, 0);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(5, 1);
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                    nb[r] += len;
                end
            end
            model_build();
            wait_done(exp_q.size(), "rand");
            total += 3;
            if (obs.size() != exp_q.size()) begin
                bad++; $display("FAIL rand_len round=%0d got=%0d want=%0d", rnd, obs.size(), exp_q.size());
            end
            if (terr_cnt != 0)    begin bad++; $display("FAIL rand_timeout round=%0d got=%0d want=0", rnd, terr_cnt); end
            if (onehot_viol != 0) begin bad++; $display("FAIL rand_onehot round=%0d got=%0d want=0", rnd, onehot_viol); end
            for (int r = 0; r < NR; r++) begin
                total++;
                if (rdy_cnt[r] != nb[r]) begin
                    bad++; $display("FAIL rand_ready round=%0d req=%0d got=%0d want=%0d", rnd, r, rdy_cnt[r], nb[r]);
                end
            end
            for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
                total++;
                if (obs[k] !== exp_q[k]) begin
                    bad++; $display("FAIL rand_byte round=%0d idx=%0d got=%h want=%h", rnd, k, obs[k], exp_q[k]);
                end
            end
            clear_env();
        end
        gaps_on = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        clear_env();
        test_reset();
        test_single_stream();
        test_contention();
        test_mid_packet();
        test_timeout();
        test_reset_in_flight();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
